// File: rtl/gnn_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gnn_operand_sequencer
// Description : Streams neighbour feature words paired with a node weight into
//               the GNN MAC core and flags when the core has absorbed each node.
// Revision    : 1.0
// ============================================================================
module gnn_operand_sequencer #(
    parameter int DATA_W   = 128,
    parameter int DEG_W    = 8,
    parameter int PIPE_LAT = 5,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [DATA_W-1:0] desc_weight,
    input  logic [DEG_W-1:0]  desc_degree,
    input  logic              feat_valid,
    output logic              feat_ready,
    input  logic [DATA_W-1:0] feat_data,
    output logic [DATA_W-1:0] input_a,
    output logic [DATA_W-1:0] input_b,
    output logic              node_done,
    output logic [CNT_W-1:0]  nodes_done_cnt,
    output logic              busy
);

    localparam logic [0:0]       c_ST_IDLE   = 1'b0;
    localparam logic [0:0]       c_ST_STREAM = 1'b1;
    localparam logic [DEG_W-1:0] c_DEG_ONE   = {{(DEG_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]          r_state;
    logic [DATA_W-1:0]   r_weight;
    logic [DEG_W-1:0]    r_remaining;
    logic [DATA_W-1:0]   r_input_a;
    logic [DATA_W-1:0]   r_input_b;
    logic [PIPE_LAT-1:0] r_delay;
    logic                r_node_done;
    logic [CNT_W-1:0]    r_nodes_done_cnt;

    logic                w_desc_fire;
    logic                w_feat_fire;
    logic                w_last_beat;
    logic                w_inject;
    logic [PIPE_LAT-1:0] w_delay_next;

    assign desc_ready  = (r_state == c_ST_IDLE);
    assign feat_ready  = (r_state == c_ST_STREAM);
    assign w_desc_fire = desc_valid && desc_ready;
    assign w_feat_fire = feat_valid && feat_ready;
    assign w_last_beat = w_feat_fire && (r_remaining == c_DEG_ONE);

    // A node completes either on its final beat or, with no neighbours, on acceptance.
    assign w_inject = w_last_beat || (w_desc_fire && (desc_degree == '0));

    generate
        if (PIPE_LAT == 1) begin : g_delay_single
            assign w_delay_next = w_inject;
        end else begin : g_delay_shift
            assign w_delay_next = {r_delay[PIPE_LAT-2:0], w_inject};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_ST_IDLE;
            r_weight         <= '0;
            r_remaining      <= '0;
            r_input_a        <= '0;
            r_input_b        <= '0;
            r_delay          <= '0;
            r_node_done      <= 1'b0;
            r_nodes_done_cnt <= '0;
        end else begin
            // The core multiplies every cycle, so idle cycles must present zeros.
            if (w_feat_fire) begin
                r_input_a <= feat_data;
                r_input_b <= r_weight;
            end else begin
                r_input_a <= '0;
                r_input_b <= '0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_desc_fire) begin
                        r_weight <= desc_weight;
                        if (desc_degree != '0) begin
                            r_remaining <= desc_degree;
                            r_state     <= c_ST_STREAM;
                        end
                    end
                end
                c_ST_STREAM: begin
                    if (w_feat_fire) begin
                        r_remaining <= r_remaining - c_DEG_ONE;
                        if (w_last_beat) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            r_delay     <= w_delay_next;
            r_node_done <= r_delay[PIPE_LAT-1];
            if (r_delay[PIPE_LAT-1]) begin
                r_nodes_done_cnt <= r_nodes_done_cnt + c_CNT_ONE;
            end
        end
    end

    assign input_a        = r_input_a;
    assign input_b        = r_input_b;
    assign node_done      = r_node_done;
    assign nodes_done_cnt = r_nodes_done_cnt;
    assign busy           = (r_state != c_ST_IDLE) || (|r_delay);

endmodule
`default_nettype wire

// File: tb/tb_gnn_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gnn_operand_sequencer
// Description : Directed bench with a transaction-level model and a MAC core model.
// Revision    : 1.0
// ============================================================================
module tb_gnn_operand_sequencer;

    localparam int DATA_W   = 128;
    localparam int DEG_W    = 8;
    localparam int PIPE_LAT = 5;
    localparam int CNT_W    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              desc_valid;
    logic              desc_ready;
    logic [DATA_W-1:0] desc_weight;
    logic [DEG_W-1:0]  desc_degree;
    logic              feat_valid;
    logic              feat_ready;
    logic [DATA_W-1:0] feat_data;
    logic [DATA_W-1:0] input_a;
    logic [DATA_W-1:0] input_b;
    logic              node_done;
    logic [CNT_W-1:0]  nodes_done_cnt;
    logic              busy;

    always #5 clk = ~clk;

    gnn_operand_sequencer #(
        .DATA_W  (DATA_W),
        .DEG_W   (DEG_W),
        .PIPE_LAT(PIPE_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_weight   (desc_weight),
        .desc_degree   (desc_degree),
        .feat_valid    (feat_valid),
        .feat_ready    (feat_ready),
        .feat_data     (feat_data),
        .input_a       (input_a),
        .input_b       (input_b),
        .node_done     (node_done),
        .nodes_done_cnt(nodes_done_cnt),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    bit armed    = 1'b0;

    // Transaction-level expectation: beats left in the current node, and the
    // absolute edge numbers at which completion pulses are due.
    int                m_left;
    logic [DATA_W-1:0] m_weight;
    int                m_done_q[$];
    logic [CNT_W-1:0]  m_cnt;
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_b;
    logic              exp_done;

    // MAC core as seen from the DUT operands: product pipeline feeding an accumulator.
    logic [DATA_W-1:0] core_pipe[PIPE_LAT];
    logic [DATA_W-1:0] core_acc;
    int                pulse_edges[$];
    logic [DATA_W-1:0] pulse_macs[$];
    bit                nonzero_seen;
    bit                feat_ready_seen;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            edge_n++;
            if (reset) begin
                armed    = 1'b1;
                m_left   = 0;
                m_weight = '0;
                m_done_q.delete();
                m_cnt    = '0;
                exp_a    = '0;
                exp_b    = '0;
                exp_done = 1'b0;
                core_acc = '0;
                for (int i = 0; i < PIPE_LAT; i++) core_pipe[i] = '0;
            end else if (armed) begin
                exp_done = 1'b0;
                for (int i = m_done_q.size() - 1; i >= 0; i--) begin
                    if (m_done_q[i] == edge_n) begin
                        exp_done = 1'b1;
                        m_done_q.delete(i);
                    end
                end
                if (exp_done) m_cnt = m_cnt + 1'b1;

                if (m_left != 0 && feat_valid) begin
                    exp_a  = feat_data;
                    exp_b  = m_weight;
                    m_left = m_left - 1;
                    if (m_left == 0) m_done_q.push_back(edge_n + PIPE_LAT);
                end else begin
                    exp_a = '0;
                    exp_b = '0;
                    if (m_left == 0 && desc_valid) begin
                        m_weight = desc_weight;
                        if (desc_degree == 0) m_done_q.push_back(edge_n + PIPE_LAT);
                        else m_left = int'(desc_degree);
                    end
                end

                core_acc = core_acc + core_pipe[PIPE_LAT-1];
                for (int i = PIPE_LAT - 1; i > 0; i--) core_pipe[i] = core_pipe[i-1];
                core_pipe[0] = input_a * input_b;
            end

            if (armed) begin
                check("input_a", input_a, exp_a);
                check("input_b", input_b, exp_b);
                check("node_done", node_done, exp_done);
                check("nodes_done_cnt", nodes_done_cnt, m_cnt);
                check("desc_ready", desc_ready, m_left == 0);
                check("feat_ready", feat_ready, m_left != 0);
                check("busy", busy, (m_left != 0) || (m_done_q.size() != 0));
                if (node_done === 1'b1) begin
                    pulse_edges.push_back(edge_n);
                    pulse_macs.push_back(core_acc);
                end
                if (input_a != '0 || input_b != '0) nonzero_seen = 1'b1;
                if (feat_ready === 1'b1) feat_ready_seen = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_obs();
        pulse_edges.delete();
        pulse_macs.delete();
        nonzero_seen    = 1'b0;
        feat_ready_seen = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_obs();
    endtask

    task automatic send_desc(input int w, input int d, output int e);
        desc_valid  = 1'b1;
        desc_weight = DATA_W'(w);
        desc_degree = DEG_W'(d);
        tick();
        desc_valid  = 1'b0;
        e = edge_n;
    endtask

    task automatic beat(input int f, output int e);
        feat_valid = 1'b1;
        feat_data  = DATA_W'(f);
        tick();
        feat_valid = 1'b0;
        e = edge_n;
    endtask

    task automatic check_pulse(input string name, input int idx, input int exp_edge,
                               input int exp_mac);
        if (pulse_edges.size() > idx) begin
            check({name, "_edge"}, pulse_edges[idx], exp_edge);
            check({name, "_mac"}, pulse_macs[idx], exp_mac);
        end else begin
            check({name, "_present"}, 0, 1);
        end
    endtask

    int e0, e1, e2;
    int be[3];

    initial begin
        reset       = 1'b1;
        desc_valid  = 1'b0;
        desc_weight = '0;
        desc_degree = '0;
        feat_valid  = 1'b0;
        feat_data   = '0;
        clear_obs();

        // Idle after reset
        do_reset();
        repeat (10) tick();
        check("t1_pulses", pulse_edges.size(), 0);
        check("t1_cnt", nodes_done_cnt, 0);
        check("t1_busy", busy, 0);
        check("t1_a", input_a, 0);
        check("t1_b", input_b, 0);

        // weight 3, features 5 and 7 back to back
        do_reset();
        send_desc(3, 2, e0);
        beat(5, e1);
        beat(7, e2);
        repeat (8) tick();
        check("t2_pulses", pulse_edges.size(), 1);
        check_pulse("t2_pulse", 0, e2 + 5, 36);
        check("t2_from_desc", e2 + 5 - e0, 7);
        check("t2_cnt", nodes_done_cnt, 1);

        // Same node with a 3-cycle feature stall
        do_reset();
        send_desc(3, 2, e0);
        beat(5, e1);
        repeat (3) tick();
        beat(7, e2);
        repeat (8) tick();
        check("t3_pulses", pulse_edges.size(), 1);
        check_pulse("t3_pulse", 0, e0 + 10, 36);
        check("t3_cnt", nodes_done_cnt, 1);

        // Degree-0 node, with stray feature words offered while idle
        do_reset();
        send_desc(9, 0, e0);
        feat_valid = 1'b1;
        feat_data  = 128'h55;
        repeat (3) tick();
        feat_valid = 1'b0;
        repeat (4) tick();
        check("t4_pulses", pulse_edges.size(), 1);
        check_pulse("t4_pulse", 0, e0 + 5, 0);
        check("t4_nonzero_ops", nonzero_seen, 0);
        check("t4_feat_ready", feat_ready_seen, 0);

        // Three degree-1 nodes back to back
        do_reset();
        for (int n = 0; n < 3; n++) begin
            send_desc(n + 1, 1, e0);
            beat(10, be[n]);
        end
        repeat (8) tick();
        check("t5_pulses", pulse_edges.size(), 3);
        check_pulse("t5_p0", 0, be[0] + 5, 10);
        check_pulse("t5_p1", 1, be[1] + 5, 30);
        check_pulse("t5_p2", 2, be[2] + 5, 60);
        check("t5_cnt", nodes_done_cnt, 3);

        // Reset two beats into a degree-4 node, then a fresh node
        do_reset();
        send_desc(7, 4, e0);
        beat(1, e1);
        beat(2, e2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_a_after_reset", input_a, 0);
        check("t6_b_after_reset", input_b, 0);
        check("t6_busy_after_reset", busy, 0);
        clear_obs();
        repeat (8) tick();
        check("t6_no_pulse", pulse_edges.size(), 0);
        send_desc(2, 1, e0);
        beat(4, e1);
        repeat (8) tick();
        check("t6_pulses", pulse_edges.size(), 1);
        check_pulse("t6_pulse", 0, e1 + 5, 8);
        check("t6_cnt", nodes_done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gnn_operand_sequencer.md
Name: gnn_operand_sequencer

Overview:
- Upstream feeder for the GNN MAC core: drives its input_a/input_b operand pair every cycle.
- Per node, accepts a descriptor (weight vector and neighbour count), then streams that many neighbour feature words paired with the weight.
- The MAC core has no enable and multiplies every cycle, so this block drives zero operands whenever no beat is issued, leaving the accumulator unchanged.
- Emits node_done aligned with the cycle the core's accumulator first includes a node's final product.

Parameters:
- DATA_W, 128, operand width (equals core input width).
- DEG_W, 8, width of neighbour-count field.
- PIPE_LAT, 5, edges from operand register update to core accumulator update (4 product stages + accumulate).
- CNT_W, 16, width of completed-node counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- desc_valid  input  1  descriptor valid.
- desc_ready  output  1  descriptor accepted when valid&ready.
- desc_weight  input  DATA_W  weight vector for node.
- desc_degree  input  DEG_W  neighbour count (0 legal).
- feat_valid  input  1  feature word valid.
- feat_ready  output  1  feature accepted when valid&ready.
- feat_data  input  DATA_W  neighbour feature word.
- input_a  output  DATA_W  registered feature operand to core.
- input_b  output  DATA_W  registered weight operand to core.
- node_done  output  1  one-cycle pulse: core accumulator now includes node's last product.
- nodes_done_cnt  output  CNT_W  completed-node count, wraps.
- busy  output  1  FSM not IDLE or any done pending in the delay line.

Behaviour:
- Single clock domain; all state updates on the rising edge of clk. reset is synchronous and active-high.
- Reset values: state=IDLE, input_a=0, input_b=0, weight reg=0, remaining=0, delay line=0, node_done=0, nodes_done_cnt=0, busy=0.
- FSM states:
  - IDLE: desc_ready=1, feat_ready=0.
  - STREAM: desc_ready=0, feat_ready=1.
- Transitions from IDLE on a desc handshake:
  - Latch desc_weight into the weight reg.
  - degree>0: remaining=degree, go to STREAM.
  - degree==0: stay in IDLE and inject a done token into the delay line on the same edge.
- STREAM beat (feat handshake): on that edge input_a<=feat_data, input_b<=weight reg, remaining decrements.
  - On the beat with remaining==1: inject a done token and return to IDLE.
  - Nodes may run back to back; the next descriptor can be accepted the cycle after the last beat.
- On any edge without a feat handshake (IDLE, or STREAM with feat_valid=0): input_a<=0 and input_b<=0.
  - Upstream stalls therefore add a zero product only.
  - Weights are never reused silently.
- Done delay line: PIPE_LAT-deep shift register. A token injected at edge E0 makes node_done high for exactly the cycle after edge E0+PIPE_LAT.
  - This is the first cycle the core's mac_out includes the beat issued at E0.
  - Degree-0 nodes pulse PIPE_LAT edges after descriptor acceptance.
- Multiple tokens may be in flight; each produces its own pulse. Consecutive nodes can pulse on consecutive cycles.
- nodes_done_cnt increments on the same edge node_done rises, i.e. it is visible together with the pulse. It wraps from 2^CNT_W-1 to 0.
- busy = (state!=IDLE) | (|delay_line).
- Reset mid-operation:
  - Abandons the current node and flushes all pending tokens; no pulse is issued for them.
  - Operands go to zero the cycle after reset is sampled.
- feat_valid in IDLE is ignored (feat_ready=0). desc_valid in STREAM is held off (desc_ready=0).
- No internal arithmetic on data. Operands pass through unchanged at full DATA_W.

Test Plan:
- Reset, then idle 10 cycles -> input_a=input_b=0, node_done never pulses, nodes_done_cnt=0, busy=0.
- Descriptor weight=3, degree=2, features 5 and 7 on consecutive cycles -> operand pairs (5,3) then (7,3), then zeros. node_done pulses exactly once, PIPE_LAT edges after the second beat's edge. Core mac_out=36 on that cycle. nodes_done_cnt=1.
- Same node with feat_valid low for 3 cycles between the two beats -> zero operands during the gap. Pulse is delayed by 3 cycles. mac_out still 36.
- Degree-0 descriptor -> no nonzero operands. node_done pulses PIPE_LAT edges after desc acceptance. FSM never leaves IDLE.
- Three degree-1 nodes back to back with weights 1,2,3 and features 10,10,10 -> node_done pulses at the expected edges. mac_out reads 10, 30, 60 at the three pulses. nodes_done_cnt=3.
- Assert reset two cycles into a degree-4 node -> no node_done pulse. busy=0 and operands=0 after reset. A new node afterwards completes normally.
